// File: rtl/fft_64_frame_sink.sv
// Frame sink for the 64-point streaming FFT: it captures 4-lane beats into ping-pong banks and replays them one sample per cycle.
// Latency: m_valid rises on the 2nd cycle after the beat-15 write cycle when the reader is idle; after that, throughput is 1 sample per cycle.
// Backpressure: m_ready low holds m_data/m_last stable. If a frame starts while both banks are full, it is dropped and counted.
//
// Ports:
//   clk, rst          - single clock, synchronous active-high reset
//   x_*_in / y_*_in   - real/imag of lanes a..d (lane l of beat t lands at position 4*t+l)
//   ctrl_in           - one-cycle pulse on beat t=0 of a frame
//   m_data/m_valid/m_ready/m_last - single-sample output stream, m_data = {x, y}
//   overflow, drop_cnt - sticky drop flag and saturating count of dropped frames
//
// Build option: define FFT_SINK_DIGIT_REV_EN to emit samples in natural frequency order
// (base-4 digit reversal of the read index). Leave it undefined to emit samples in arrival order.
module fft_64_frame_sink #(
    parameter int DATA_WIDTH   = 16,
    parameter int PROBLEM_SIZE = 64,
    parameter int NUM_BANKS    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   x_a_in,
    input  logic [DATA_WIDTH-1:0]   y_a_in,
    input  logic [DATA_WIDTH-1:0]   x_b_in,
    input  logic [DATA_WIDTH-1:0]   y_b_in,
    input  logic [DATA_WIDTH-1:0]   x_c_in,
    input  logic [DATA_WIDTH-1:0]   y_c_in,
    input  logic [DATA_WIDTH-1:0]   x_d_in,
    input  logic [DATA_WIDTH-1:0]   y_d_in,
    input  logic                    ctrl_in,
    output logic [2*DATA_WIDTH-1:0] m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    m_last,
    output logic                    overflow,
    output logic [7:0]              drop_cnt
);

    typedef enum logic {
        W_IDLE = 1'b0,
        W_FILL = 1'b1
    } wstate_t;

    // Frame storage; the contents need no reset because a bank is only read after it has been completely written.
    logic [2*DATA_WIDTH-1:0] mem_q [NUM_BANKS][PROBLEM_SIZE];

    // Writer state
    wstate_t     wstate_q;
    logic        wbank_q;
    logic [3:0]  wbeat_q;

    // Bank bookkeeping. oldest_q identifies the bank that filled first, and it only matters while both banks are full.
    logic [1:0]  full_q;
    logic        oldest_q;

    // Reader / output register stage
    logic                    m_valid_q;
    logic                    m_last_q;
    logic [2*DATA_WIDTH-1:0] m_data_q;
    logic                    rd_bank_q;
    logic [5:0]              rd_k_q;
    logic                    overflow_q;
    logic [7:0]              drop_cnt_q;

    // Combinational next-state / control
    logic        hs;
    logic        rd_done;
    logic [1:0]  clr_vec;
    logic [1:0]  set_vec;
    logic [1:0]  free_vec;
    logic        has_free;
    logic        free_sel;
    logic        wr_start;
    logic        wr_drop;
    logic        wr_en;
    logic        wr_bank;
    logic [3:0]  wr_beat;
    logic        fill_done;

    logic        rd_load;
    logic        m_valid_d;
    logic        rd_bank_d;
    logic [5:0]  rd_k_d;
    logic [5:0]  rd_addr;
    logic [2*DATA_WIDTH-1:0] rd_dat;

    // This function maps the sample index to the storage position.
    function automatic logic [5:0] rev_idx(input logic [5:0] k);
`ifdef FFT_SINK_DIGIT_REV_EN
        // Reverse the three base-4 digits: d2 d1 d0 -> d0 d1 d2.
        return {k[1:0], k[3:2], k[5:4]};
`else
        return k;
`endif
    endfunction

    assign m_data   = m_data_q;
    assign m_valid  = m_valid_q;
    assign m_last   = m_last_q;
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;

    // Reader frees its bank on the k=63 handshake.
    assign hs      = m_valid_q & m_ready;
    assign rd_done = hs & (rd_k_q == 6'd63);
    assign clr_vec = {rd_done & rd_bank_q, rd_done & ~rd_bank_q};

    // The free vector includes a bank released on this same edge, so a ctrl_in that coincides with the release still finds room.
    assign free_vec = ~full_q | clr_vec;
    assign has_free = |free_vec;
    assign free_sel = ~free_vec[0];

    assign wr_start  = (wstate_q == W_IDLE) & ctrl_in & has_free;
    assign wr_drop   = (wstate_q == W_IDLE) & ctrl_in & ~has_free;
    assign wr_en     = wr_start | (wstate_q == W_FILL);
    assign wr_bank   = (wstate_q == W_FILL) ? wbank_q : free_sel;
    // A ctrl_in in FILL restarts the frame at beat 0 in the same bank.
    assign wr_beat   = ctrl_in ? 4'd0 : wbeat_q;
    assign fill_done = (wstate_q == W_FILL) & ~ctrl_in & (wbeat_q == 4'd15);
    assign set_vec   = {fill_done & wbank_q, fill_done & ~wbank_q};

    // Reader next-state logic. This logic decides whether the output register loads a new sample at this edge.
    always_comb begin
        rd_load   = 1'b0;
        m_valid_d = m_valid_q;
        rd_bank_d = rd_bank_q;
        rd_k_d    = rd_k_q;
        if (m_valid_q) begin
            if (hs) begin
                if (rd_k_q == 6'd63) begin
                    rd_k_d    = 6'd0;
                    rd_bank_d = ~rd_bank_q;
                    // If the other bank is already full, the stream continues into it with no bubble.
                    if (full_q[~rd_bank_q]) begin
                        rd_load = 1'b1;
                    end else begin
                        m_valid_d = 1'b0;
                    end
                end else begin
                    rd_k_d  = rd_k_q + 6'd1;
                    rd_load = 1'b1;
                end
            end
        end else if (|full_q) begin
            // When idle, pick the oldest full bank. If only one bank is full, that bank is the oldest.
            rd_bank_d = (&full_q) ? oldest_q : full_q[1];
            rd_k_d    = 6'd0;
            rd_load   = 1'b1;
            m_valid_d = 1'b1;
        end
    end

    assign rd_addr = rev_idx(rd_k_d);
    assign rd_dat  = mem_q[rd_bank_d][rd_addr];

    // Frame memory write port: four lanes per beat.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_bank][{wr_beat, 2'd0}] <= {x_a_in, y_a_in};
            mem_q[wr_bank][{wr_beat, 2'd1}] <= {x_b_in, y_b_in};
            mem_q[wr_bank][{wr_beat, 2'd2}] <= {x_c_in, y_c_in};
            mem_q[wr_bank][{wr_beat, 2'd3}] <= {x_d_in, y_d_in};
        end
    end

    // Control state: writer FSM, bank flags, reader and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wstate_q   <= W_IDLE;
            wbank_q    <= 1'b0;
            wbeat_q    <= 4'd0;
            full_q     <= 2'b00;
            oldest_q   <= 1'b0;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
            m_data_q   <= '0;
            rd_bank_q  <= 1'b0;
            rd_k_q     <= 6'd0;
            overflow_q <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            case (wstate_q)
                W_IDLE: begin
                    if (wr_start) begin
                        wstate_q <= W_FILL;
                        wbank_q  <= free_sel;
                        wbeat_q  <= 4'd1;
                    end
                end
                W_FILL: begin
                    if (ctrl_in) begin
                        wbeat_q <= 4'd1;
                    end else if (wbeat_q == 4'd15) begin
                        wstate_q <= W_IDLE;
                        wbeat_q  <= 4'd0;
                    end else begin
                        wbeat_q <= wbeat_q + 4'd1;
                    end
                end
                default: begin
                    wstate_q <= W_IDLE;
                end
            endcase

            if (wr_drop) begin
                overflow_q <= 1'b1;
                if (drop_cnt_q != 8'hFF) begin
                    drop_cnt_q <= drop_cnt_q + 8'd1;
                end
            end

            // The set and the clear always target different banks, because a bank being filled is never full.
            full_q <= (full_q & ~clr_vec) | set_vec;
            if (fill_done && !full_q[~wbank_q]) begin
                oldest_q <= wbank_q;
            end

            m_valid_q <= m_valid_d;
            rd_bank_q <= rd_bank_d;
            rd_k_q    <= rd_k_d;
            if (rd_load) begin
                m_data_q <= rd_dat;
                m_last_q <= (rd_k_d == 6'd63);
            end else if (!m_valid_d) begin
                m_last_q <= 1'b0;
            end
        end
    end

endmodule

// File: doc/fft_64_frame_sink.md
Name: fft_64_frame_sink

Overview:
- Receive end of the 64-point streaming FFT output interface: 4 complex lanes per cycle, 16 cycles per frame, frame start marked by a one-cycle ctrl pulse.
- Captures each frame into a ping-pong buffer and replays it as a single-sample valid/ready stream in natural frequency order, with an end-of-frame marker.
- Sits between the FFT core output register stage and the host/DMA side.

Parameters:
- DATA_WIDTH, 16, width of each real/imag component.
- PROBLEM_SIZE, 64, points per frame; fixed at 64, with 16 input cycles per frame at 4 lanes.
- NUM_BANKS, 2, frame buffers (ping-pong); fixed at 2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- x_a_in, y_a_in, x_b_in, y_b_in, x_c_in, y_c_in, x_d_in, y_d_in  in  DATA_WIDTH each  real/imag of lanes a..d.
- ctrl_in  in  1  one-cycle pulse coincident with the first beat (t=0) of a frame.
- m_data  out  2*DATA_WIDTH  {x, y} of the current output sample.
- m_valid  out  1  m_data is valid.
- m_ready  in  1  consumer accepts when m_valid && m_ready.
- m_last  out  1  high with sample k=63.
- overflow  out  1  sticky; a frame was dropped.
- drop_cnt  out  8  count of dropped frames; saturates at 255.

Behaviour:
- Reset: the single clock is clk. Reset is synchronous and active-high on rst. rst=1 clears m_data, m_valid, m_last, overflow and drop_cnt to 0, marks both banks empty, idles the writer and sets the read index to 0. Memory contents are don't-care.
- Writer FSM with states IDLE and FILL:
  - IDLE -> FILL on ctrl_in when a non-full bank exists. The writer picks the lowest-numbered empty bank, and the beat at t=0 is written in that same cycle.
  - In FILL, beats t=1..15 are written on each consecutive cycle, with no gaps allowed.
  - Lane l (a=0, b=1, c=2, d=3) at beat t is stored at position p = 4*t + l.
  - After the t=15 write, the bank is marked full on the next edge and the FSM returns to IDLE.
- ctrl_in during FILL: the partial frame is discarded and the fill restarts at t=0 in the same bank. No overflow is flagged.
- ctrl_in with both banks full: the frame is dropped. overflow is set to 1 and drop_cnt increments (saturating). The FSM stays IDLE and ignores the following 15 beats unless another ctrl_in arrives.
- Reader:
  - Operates on the oldest full bank, alternating banks.
  - Output register stage: m_valid asserts on the 2nd cycle after the t=15 write cycle, provided the reader is idle.
  - Sample k comes from position rev(k) (see Optional Feature). m_last = (k==63).
  - On each handshake, k increments and the next sample is loaded the same edge, giving back-to-back throughput of 1 sample/cycle.
  - After the k=63 handshake, the bank is marked empty and k wraps to 0. If the other bank is already full, m_valid stays high and it streams with no bubble.
- Stall: while m_valid && !m_ready, m_data and m_last hold stable.
- Simultaneous events:
  - Bank-full set (writer) and bank-empty clear (reader) on different banks in the same cycle both take effect.
  - A bank freed on the same edge a ctrl_in arrives is available to that ctrl_in. The free becomes visible combinationally to the bank select, so there is no drop.
- Reset mid-frame or mid-readout aborts everything. The first m_valid after reset requires a complete new frame.
- Arithmetic: no data arithmetic; samples pass through bit-exact.

Optional Feature:
- Macro FFT_SINK_DIGIT_REV_EN.
- Defined: rev(k) reverses the three base-4 digits of k. For k = 16*d2 + 4*d1 + d0, rev(k) = 16*d0 + 4*d1 + d2. The output is in natural frequency order.
- Undefined: rev(k) = k. Samples are emitted in arrival order p, and the reorder logic is not synthesised.
- Latency and handshakes are identical in both builds.

Test Plan:
- Reset, then one frame with x=p, y=256+p (p=4t+l), m_ready=1, macro defined -> m_valid rises 2 cycles after beat 15; 64 consecutive samples, the k-th with x=rev(k) (k=1 -> x=16, k=4 -> x=4, k=63 -> x=63); m_last only on the 64th; overflow=0.
- Same stimulus, macro undefined -> x = 0,1,2,...,63 in order.
- Three back-to-back frames, m_ready=0 until all sent -> frames 1 and 2 buffered, frame 3 dropped, overflow=1, drop_cnt=1. On release, exactly 128 samples with m_last at samples 64 and 128.
- m_ready toggling 1/0 every cycle -> m_data unchanged across each stalled cycle; 64 samples total with none lost or duplicated.
- ctrl_in re-asserted at beat t=7, followed by a full new frame -> only the new frame is output (64 samples); overflow=0.
- rst pulsed while sample k=20 is pending -> the next cycle has m_valid=0, overflow=0, drop_cnt=0; a subsequent frame outputs from k=0.
